// File: rtl/sigmoid_pkg.sv
// Shared Q-format constants, PLAN segment parameters and FSM state type for the
// sigmoid / logit datapaths.
package sigmoid_pkg;

  localparam int XW = 8;   // x: signed Q3.4, 1.0 = 16
  localparam int PW = 16;  // p: signed Q1.14, 1.0 = 16384

  localparam logic [PW-1:0] ONE_Q14 = 16'd16384;

  // Breakpoints on |x| in Q3.4 (9 bits so |-8.0| = 128 fits)
  localparam logic [XW:0] BP_SAT = 9'd80;  // 5.0
  localparam logic [XW:0] BP_HI  = 9'd38;  // 2.375
  localparam logic [XW:0] BP_MID = 9'd16;  // 1.0

  // Segment offsets in Q1.14
  localparam logic [PW-1:0] OFS_HI  = 16'd13824;  // 0.84375
  localparam logic [PW-1:0] OFS_MID = 16'd10240;  // 0.625
  localparam logic [PW-1:0] OFS_LO  = 16'd8192;   // 0.5

  // Result codes that mark a saturated logit
  localparam logic [XW-1:0] X_MAX = 8'h7F;
  localparam logic [XW-1:0] X_MIN = 8'h80;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  // Probabilities outside [0, 1.0] are pinned to the nearest end.
  function automatic logic [PW-1:0] clamp_p(input logic [PW-1:0] p);
    if (p[PW-1])          return '0;
    else if (p > ONE_Q14) return ONE_Q14;
    else                  return p;
  endfunction

endpackage

// File: rtl/sigmoid_plan_eval.sv
// Combinational PLAN sigmoid: signed Q3.4 x -> Q1.14 f(x). Same arithmetic as
// the forward unit, so the inverse search lands on bit-identical codes.
module sigmoid_plan_eval
  import sigmoid_pkg::*;
(
  input  logic [XW-1:0] x,
  output logic [PW-1:0] f
);

  logic [XW:0]   a;
  logic [PW-1:0] fa;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    // Sign-extend before negating so x = -128 gives |x| = 128
    a = x[XW-1] ? (9'd0 - {1'b1, x}) : {1'b0, x};

    if (a >= BP_SAT)      fa = ONE_Q14;
    else if (a >= BP_HI)  fa = (PW'(a) << 5) + OFS_HI;   // a/32 + 0.84375
    else if (a >= BP_MID) fa = (PW'(a) << 7) + OFS_MID;  // a/8  + 0.625
    else                  fa = (PW'(a) << 8) + OFS_LO;   // a/4  + 0.5

    // fa never exceeds 1.0, so the mirrored half stays inside [0, 1.0]
    f = x[XW-1] ? (ONE_Q14 - fa) : fa;
  end

endmodule

// File: rtl/logit_sar.sv
// Inverse PLAN sigmoid: successive-approximation search for the largest Q3.4 x
// with f(x) <= p, one bit per clock after a one-cycle input conditioning step.
module logit_sar
  import sigmoid_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] p_in,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_out,
  output logic          sat
);

  state_t        state, state_nx;
  logic [XW:0]   mask;     // bit XW marks the clamp step, then one-hot trial bit
  logic [XW-1:0] u;        // offset-binary code, x = u - 128
  logic [PW-1:0] p_q;
  logic [XW-1:0] trial, u_next, x_next;
  logic [PW-1:0] f_trial;
  logic          accept;

  assign accept = start && (state == IDLE || state == DONE);
  assign trial  = u | mask[XW-1:0];
  assign busy   = (state == SEARCH);
  assign done   = (state == DONE);

  // Offset code to two's complement is an MSB flip
  sigmoid_plan_eval u_eval (
    .x (trial ^ X_MIN),
    .f (f_trial)
  );

  assign u_next = (f_trial <= p_q) ? trial : u;
  assign x_next = u_next ^ X_MIN;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SEARCH;
      SEARCH:  if (mask[0]) state_nx = DONE;
      DONE:    state_nx = start ? SEARCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mask  <= '0;
      u     <= '0;
      p_q   <= '0;
      x_out <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        p_q  <= p_in;
        u    <= '0;
        mask <= {1'b1, {XW{1'b0}}};
      end else if (state == SEARCH) begin
        mask <= mask >> 1;
        // First search cycle conditions the raw sample, keeping p_in's path a plain load
        if (mask[XW]) p_q <= clamp_p(p_q);
        else          u   <= u_next;
        if (mask[0]) begin
          x_out <= x_next;
          sat   <= (x_next == X_MAX) || (x_next == X_MIN);
        end
      end
    end
  end

endmodule

// File: tb/tb_logit_sar.sv
// Scoreboard bench for logit_sar: expectations come from a real-valued PLAN
// model and a brute-force "largest x with f(x) <= p" search.
module tb_logit_sar;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] p_in = '0;
  logic        busy, done, sat;
  logic [7:0]  x_out;

  logic [7:0]  ex;
  logic [15:0] ef;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    logic [7:0] x;
    logic       s;
    int         acc;
  } exp_t;
  exp_t sb[$];

  logit_sar dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p_in  (p_in),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .sat   (sat)
  );

  sigmoid_plan_eval u_ref_eval (
    .x (ex),
    .f (ef)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // PLAN sigmoid straight from its segment definitions, in real arithmetic
  function automatic int f_ref(input int x);
    real a, y;
    a = (x < 0 ? -x : x) / 16.0;
    if (a >= 5.0)        y = 1.0;
    else if (a >= 2.375) y = a / 32.0 + 0.84375;
    else if (a >= 1.0)   y = a / 8.0 + 0.625;
    else                 y = a / 4.0 + 0.5;
    if (x < 0) y = 1.0 - y;
    return int'(y * 16384.0);
  endfunction

  function automatic int logit_ref(input logic [15:0] p);
    int pc, best;
    if (p[15])          pc = 0;
    else if (p > 16384) pc = 16384;
    else                pc = int'(p);
    best = -128;
    for (int x = -128; x < 128; x++)
      if (f_ref(x) <= pc) best = x;
    return best;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("x_out", int'(x_out), int'(e.x));
        check("sat", int'(sat), int'(e.s));
        check("latency", cyc - e.acc, 9);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  // Accept edge is the posedge following this negedge, i.e. edge cyc+1
  task automatic issue(input logic [15:0] p, input logic [7:0] xe, input logic se);
    @(negedge clk);
    p_in  = p;
    start = 1'b1;
    sb.push_back('{x: xe, s: se, acc: cyc + 1});
    @(posedge clk);
    #1 start = 1'b0;
    p_in = 16'($urandom);
  endtask

  task automatic run_exp(input logic [15:0] p, input logic [7:0] xe, input logic se);
    issue(p, xe, se);
    wait_done();
  endtask

  task automatic run_one(input logic [15:0] p);
    int b;
    b = logit_ref(p);
    run_exp(p, 8'(b), (b == 127) || (b == -128));
  endtask

  initial begin
    int b_a, b_b, c0;
    logic [15:0] pa, pb;

    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x_out", int'(x_out), 0);
    check("rst_sat", int'(sat), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int x = -128; x < 128; x++) begin
      ex = 8'(x);
      #1 check("plan_eval", int'(ef), f_ref(x));
    end

    run_exp(16'h2000, 8'h00, 1'b0);
    run_exp(16'h3000, 8'h10, 1'b0);
    run_exp(16'h3800, 8'h20, 1'b0);
    run_exp(16'h1000, 8'hF0, 1'b0);
    run_exp(16'h4000, 8'h7F, 1'b1);
    // f is flat at 0 for x <= -5.0, so the largest code with f <= 0 is -5.0
    run_exp(16'h0000, 8'hB0, 1'b0);
    run_exp(16'hFFFF, 8'hB0, 1'b0);
    run_exp(16'h5000, 8'h7F, 1'b1);

    repeat (3) @(negedge clk);
    check("x_hold", int'(x_out), 8'h7F);
    check("sat_hold", int'(sat), 1);

    // Back-to-back: start held through the first DONE
    pa = 16'd5000;
    pb = 16'd12000;
    b_a = logit_ref(pa);
    b_b = logit_ref(pb);
    @(negedge clk);
    p_in  = pa;
    start = 1'b1;
    c0 = cyc;
    sb.push_back('{x: 8'(b_a), s: 1'b0, acc: c0 + 1});
    sb.push_back('{x: 8'(b_b), s: 1'b0, acc: c0 + 11});
    @(posedge clk);
    #1 p_in = pb;
    wait_done();
    @(posedge clk);
    #1 start = 1'b0;
    p_in = 16'($urandom);
    wait_done();

    // A start pulse mid-search must not restart or add a result
    issue(16'h2800, 8'(logit_ref(16'h2800)), 1'b0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    p_in = 16'h0100;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    check("idle_after_ignored_start", int'(busy), 0);

    // Asynchronous reset in the middle of a search
    run_exp(16'h4000, 8'h7F, 1'b1);
    @(negedge clk);
    p_in  = 16'h2000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 check("busy_mid_search", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_x_out", int'(x_out), 0);
    check("async_rst_sat", int'(sat), 0);
    @(negedge clk);
    rst = 1'b0;
    run_exp(16'h1000, 8'hF0, 1'b0);

    // Every exact PLAN level must map back to the largest code producing it
    for (int x = -128; x < 128; x++)
      run_one(16'(f_ref(x)));

    for (int i = 0; i < 150; i++)
      run_one(16'($urandom_range(0, 16384)));
    for (int i = 0; i < 50; i++)
      run_one(16'($urandom));

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
